led_matrix_scan: RTL and testbench
==================================

Name: led_matrix_scan

Overview:
Parametrised row-scan driver for the pocket LED dot matrix. It successively enables one row and drives that row's column pattern from a frame buffer, looping continuously. Per-row dwell and a blanking gap are programmable to remove ghosting; the pixel frame is snapshotted once per frame for tear-free updates. It sits between the pixel source logic and the matrix pins, replacing fixed-rate counter/decoder scanning.

Parameters:
ROWS, 5, number of matrix rows (2..16)
COLS, 7, number of matrix columns (1..32)
DWELL_CYC, 65536, clock cycles a row is driven (>=1)
BLANK_CYC, 256, cycles with all rows/columns off before each row (>=0; 0 = no gap)
ROW_ACTIVE_LOW, 0, 1 inverts the row output polarity

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  scan enable; low forces idle (all off)
pixels  input  ROWS*COLS  frame data; bits [r*COLS +: COLS] = row r, 1 = LED on
row  output  ROWS  one-hot row enable (polarity per ROW_ACTIVE_LOW)
column  output  COLS  column data for the active row
frame_start  output  1  one-cycle pulse when a new frame snapshot is taken
row_idx  output  $clog2(ROWS)  index of current row (debug/sync)

Behaviour:
- Reset (async, rst=1): state=IDLE, row=all inactive, column=0, frame_start=0, row_idx=0, counters=0, snapshot=0.
- States: IDLE, BLANK, DRIVE. All outputs registered.
- IDLE: outputs inactive. en=1 -> BLANK, row_idx=0, snapshot<=pixels, frame_start=1 for that cycle.
- BLANK: row/column inactive for BLANK_CYC cycles, then DRIVE. If BLANK_CYC=0, BLANK is skipped (IDLE/DRIVE goes straight to DRIVE of the next row; the snapshot/frame_start rule still applies).
- DRIVE: row bit row_idx active, column = snapshot row row_idx, held exactly DWELL_CYC cycles. Then: if row_idx==ROWS-1, wrap row_idx to 0, take a new snapshot, pulse frame_start; else row_idx+1. Next state is BLANK.
- Frame period = ROWS*(BLANK_CYC+DWELL_CYC) cycles exactly, with no extra cycles at wrap.
- pixels is sampled only at the snapshot instant; mid-frame changes have no effect until the next frame.
- en low in any state: next edge -> IDLE, outputs inactive, counters cleared. Re-enable always restarts at row 0 with a fresh snapshot.
- Only one row is ever active; never two in the same cycle, including at wrap.
- Counter widths: $clog2 of max(DWELL_CYC,BLANK_CYC)+1, with no overflow at the terminal count.
- Reset mid-scan: immediate clear, independent of clock.

Optional Feature:
LED_SCAN_PWM_EN: adds input `brightness` [3:0]. When defined, within DRIVE the column is gated on only for the first (brightness+1)*DWELL_CYC/16 cycles (integer floor, min 1 cycle). The row stays active for the full DWELL_CYC, so timing is unchanged. brightness is sampled with the snapshot. When undefined, the port is absent and columns are driven for the full dwell.

Decomposition:
- Shared package `led_scan_pkg`: state enum (IDLE/BLANK/DRIVE), ROW_IDX_W/CNT_W width functions, default DWELL/BLANK constants.
- One sub-module: `scan_timer`, a loadable down-counter with terminal-count pulse, used for both BLANK and DRIVE intervals.

Test Plan:
- ROWS=5, COLS=7, DWELL=4, BLANK=1, pixels row r = 7'b1<<r, en=1 -> rows 00001..10000 in order, each 4 cycles after 1 off cycle. Column matches 1<<r. frame_start every 25 cycles.
- Change pixels mid-frame (during row 2) -> output unchanged until the row-0 DRIVE after the next frame_start, then shows new data.
- en deasserted during DRIVE of row 3 -> next cycle all outputs off. Reassert -> frame_start pulse, row 0 after 1 blank cycle.
- rst asserted asynchronously mid-DRIVE (between edges) -> row/column go inactive immediately, row_idx=0. After release with en=1, the scan restarts cleanly.
- BLANK_CYC=0, ROW_ACTIVE_LOW=1 -> rows active-low with no gap. Exactly one row low every cycle. Period = 5*DWELL.
- With LED_SCAN_PWM_EN, DWELL=16, brightness=3 -> column active for 4 of 16 cycles per row. brightness=0 -> 1 cycle. brightness=15 -> all 16.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared types and width helpers for the LED matrix row-scan driver.
package led_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam int DEF_DWELL_CYC = 65536;
    localparam int DEF_BLANK_CYC = 256;

    // Width of the row index; at least one bit.
    function automatic int row_idx_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Interval counter width; holds the longest interval without wrapping.
    function automatic int cnt_w(input int dwell, input int blank);
        int m;
        m = (dwell > blank) ? dwell : blank;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter used to time both BLANK and DRIVE intervals.
// tc is high while the count sits at zero, i.e. on the last cycle of an interval.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    // Load wins over counting; the counter parks at zero.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst)                count <= '0;
        else if (clr)           count <= '0;
        else if (load)          count <= load_val;
        else if (count != '0)   count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scan driver for an LED dot matrix: blank gap, then one row driven per
// dwell interval, with a per-frame snapshot of the pixel buffer.
// Optional macro LED_SCAN_PWM_EN adds a 4-bit brightness input that gates
// the column data to the first part of each dwell.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int ROWS           = 5,
    parameter int COLS           = 7,
    parameter int DWELL_CYC      = DEF_DWELL_CYC,
    parameter int BLANK_CYC      = DEF_BLANK_CYC,
    parameter bit ROW_ACTIVE_LOW = 1'b0
) (
    input  logic                         CLOCK_50,
    input  logic                         rst,
    input  logic                         en,
`ifdef LED_SCAN_PWM_EN
    input  logic [3:0]                   brightness,
`endif
    input  logic [ROWS*COLS-1:0]         pixels,
    output logic [ROWS-1:0]              row,
    output logic [COLS-1:0]              column,
    output logic                         frame_start,
    output logic [row_idx_w(ROWS)-1:0]   row_idx
);

    localparam int IW = row_idx_w(ROWS);
    localparam int CW = cnt_w(DWELL_CYC, BLANK_CYC);
    localparam logic [ROWS-1:0] ROW_OFF  = {ROWS{ROW_ACTIVE_LOW}};
    localparam logic [CW-1:0]   DWELL_LD = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0]   BLANK_LD = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    scan_state_e            state;
    logic [ROWS*COLS-1:0]   snap;
    logic [CW-1:0]          cnt;
    logic                   tc;
    logic                   t_clr, t_load;
    logic [CW-1:0]          t_val;
    logic                   wrap;
    logic [IW-1:0]          nxt_idx;

    function automatic logic [ROWS-1:0] row_on(input logic [IW-1:0] idx);
        return ROW_OFF ^ (ROWS'(1) << idx);
    endfunction

`ifdef LED_SCAN_PWM_EN
    logic [3:0] br_snap;
    int         on_cyc;

    // Lit portion of the dwell; first drive cycle is always lit.
    always_comb begin
        on_cyc = ((int'(br_snap) + 1) * DWELL_CYC) / 16;
        if (on_cyc < 1) on_cyc = 1;
    end
`else
    logic cnt_unused;
    assign cnt_unused = ^cnt;
`endif

    // Interval timer control: load at every state entry, clear while disabled.
    always_comb begin
        t_clr   = !en;
        t_load  = 1'b0;
        t_val   = DWELL_LD;
        wrap    = (row_idx == IW'(ROWS - 1));
        nxt_idx = wrap ? '0 : row_idx + 1'b1;
        case (state)
            IDLE:  if (en) begin
                       t_load = 1'b1;
                       t_val  = (BLANK_CYC > 0) ? BLANK_LD : DWELL_LD;
                   end
            BLANK: if (tc) t_load = 1'b1;
            DRIVE: if (tc) begin
                       t_load = 1'b1;
                       t_val  = (BLANK_CYC > 0) ? BLANK_LD : DWELL_LD;
                   end
            default: ;
        endcase
    end

    scan_timer #(.W(CW)) u_timer (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .clr      (t_clr),
        .load     (t_load),
        .load_val (t_val),
        .count    (cnt),
        .tc       (tc)
    );

    // Scan FSM with registered outputs; disable drops straight to IDLE.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            row         <= ROW_OFF;
            column      <= '0;
            frame_start <= 1'b0;
            row_idx     <= '0;
            snap        <= '0;
`ifdef LED_SCAN_PWM_EN
            br_snap     <= '0;
`endif
        end else if (!en) begin
            state       <= IDLE;
            row         <= ROW_OFF;
            column      <= '0;
            frame_start <= 1'b0;
            row_idx     <= '0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    snap        <= pixels;
`ifdef LED_SCAN_PWM_EN
                    br_snap     <= brightness;
`endif
                    frame_start <= 1'b1;
                    row_idx     <= '0;
                    if (BLANK_CYC > 0) begin
                        state  <= BLANK;
                        row    <= ROW_OFF;
                        column <= '0;
                    end else begin
                        state  <= DRIVE;
                        row    <= row_on('0);
                        column <= pixels[COLS-1:0];
                    end
                end
                BLANK: if (tc) begin
                    state  <= DRIVE;
                    row    <= row_on(row_idx);
                    column <= snap[int'(row_idx)*COLS +: COLS];
                end
                DRIVE: if (tc) begin
                    row_idx <= nxt_idx;
                    if (wrap) begin
                        snap        <= pixels;
`ifdef LED_SCAN_PWM_EN
                        br_snap     <= brightness;
`endif
                        frame_start <= 1'b1;
                    end
                    if (BLANK_CYC > 0) begin
                        state  <= BLANK;
                        row    <= ROW_OFF;
                        column <= '0;
                    end else begin
                        state  <= DRIVE;
                        row    <= row_on(nxt_idx);
                        column <= wrap ? pixels[COLS-1:0]
                                       : snap[int'(nxt_idx)*COLS +: COLS];
                    end
                end
`ifdef LED_SCAN_PWM_EN
                // Next drive cycle index is DWELL_CYC-cnt; blank columns past the lit part.
                else if ((DWELL_CYC - int'(cnt)) >= on_cyc) begin
                    column <= '0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Randomized bench: two scan drivers (with and without blank gap / row
// polarity) checked every cycle against a frame-position reference model.
module tb_led_matrix_scan;

    localparam int R  = 5;
    localparam int C  = 7;
    localparam int D0 = 4;
    localparam int B0 = 1;
`ifdef LED_SCAN_PWM_EN
    localparam int D1 = 16;
`else
    localparam int D1 = 3;
`endif
    localparam int B1 = 0;

    logic           CLOCK_50 = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic [R*C-1:0] pixels;
    logic [3:0]     brightness;
    logic [R-1:0]   row0, row1;
    logic [C-1:0]   col0, col1;
    logic           fs0, fs1;
    logic [2:0]     idx0, idx1;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state: enabled flag, cycles since enable, frame snapshot
    bit             act[2];
    int             t[2];
    logic [R*C-1:0] snap[2];
    int             br[2];
    int             dv[2] = '{D0, D1};
    int             bv[2] = '{B0, B1};
    bit             al[2] = '{1'b0, 1'b1};

    always #10 CLOCK_50 = ~CLOCK_50;

    led_matrix_scan #(.ROWS(R), .COLS(C), .DWELL_CYC(D0), .BLANK_CYC(B0), .ROW_ACTIVE_LOW(1'b0)) dut0 (
        .CLOCK_50(CLOCK_50), .rst(rst), .en(en),
`ifdef LED_SCAN_PWM_EN
        .brightness(brightness),
`endif
        .pixels(pixels), .row(row0), .column(col0), .frame_start(fs0), .row_idx(idx0));

    led_matrix_scan #(.ROWS(R), .COLS(C), .DWELL_CYC(D1), .BLANK_CYC(B1), .ROW_ACTIVE_LOW(1'b1)) dut1 (
        .CLOCK_50(CLOCK_50), .rst(rst), .en(en),
`ifdef LED_SCAN_PWM_EN
        .brightness(brightness),
`endif
        .pixels(pixels), .row(row1), .column(col1), .frame_start(fs1), .row_idx(idx1));

    // model advance: a frame is a fixed run of (blank+dwell)*rows cycles
    always @(posedge CLOCK_50) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || !en) begin
                act[k] = 1'b0;
            end else if (!act[k]) begin
                act[k] = 1'b1; t[k] = 0; snap[k] = pixels; br[k] = int'(brightness);
            end else begin
                t[k]++;
                if (t[k] % (R * (dv[k] + bv[k])) == 0) begin
                    snap[k] = pixels; br[k] = int'(brightness);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_out(input int k, output logic [R-1:0] r_o, output logic [C-1:0] c_o,
                             output logic fs, output logic [2:0] idx);
        int p, rr, q, on;
        r_o = al[k] ? {R{1'b1}} : {R{1'b0}};
        c_o = '0; fs = 1'b0; idx = '0;
        if (act[k]) begin
            p  = t[k] % (R * (dv[k] + bv[k]));
            rr = p / (dv[k] + bv[k]);
            q  = p % (dv[k] + bv[k]);
            fs  = (p == 0);
            idx = 3'(rr);
            if (q >= bv[k]) begin
                r_o = r_o ^ (R'(1) << rr);
                c_o = snap[k][rr*C +: C];
                on  = ((br[k] + 1) * dv[k]) / 16;
                if (on < 1) on = 1;
`ifdef LED_SCAN_PWM_EN
                if (q - bv[k] >= on) c_o = '0;
`endif
            end
        end
    endtask

    task automatic check_all();
        logic [R-1:0] er; logic [C-1:0] ec; logic ef; logic [2:0] ei;
        model_out(0, er, ec, ef, ei);
        chk("row0", 64'(row0), 64'(er)); chk("column0", 64'(col0), 64'(ec));
        chk("frame_start0", 64'(fs0), 64'(ef)); chk("row_idx0", 64'(idx0), 64'(ei));
        model_out(1, er, ec, ef, ei);
        chk("row1", 64'(row1), 64'(er)); chk("column1", 64'(col1), 64'(ec));
        chk("frame_start1", 64'(fs1), 64'(ef)); chk("row_idx1", 64'(idx1), 64'(ei));
    endtask

    initial begin
        logic [63:0] rnd;
        pixels = '0;
        for (int r = 0; r < R; r++) pixels[r*C +: C] = 7'd1 << r;
        brightness = 4'd3;
        repeat (2) @(negedge CLOCK_50);
        check_all();                                   // reset state
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 900; i++) begin
            @(negedge CLOCK_50);
            check_all();
            if (i == 40) pixels = {5'd0, 30'h2AAA_5555};  // mid-frame update
            if (i == 300) begin
                rst = 1'b1;
                #1;
                chk("async_rst_row0", 64'(row0), 64'(5'b00000));
                chk("async_rst_row1", 64'(row1), 64'(5'b11111));
                chk("async_rst_col0", 64'(col0), 64'd0);
                chk("async_rst_col1", 64'(col1), 64'd0);
                chk("async_rst_idx0", 64'(idx0), 64'd0);
                chk("async_rst_idx1", 64'(idx1), 64'd0);
            end
            if (i == 303) rst = 1'b0;
            if (i >= 80 && (i < 298 || i > 305)) begin
                if ($urandom % 6 == 0) begin
                    rnd = {$urandom, $urandom};
                    pixels = rnd[R*C-1:0];
                end
                if ($urandom % 10 == 0) brightness = 4'($urandom % 16);
                if (en && $urandom % 60 == 0) en = 1'b0;
                else if (!en && $urandom % 3 == 0) en = 1'b1;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
